// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl
// Time-multiplexed digit sequencer feeding a single 7-segment decoder.
// Scans DIGITS hex nibbles with a one-hot digit enable and a blank flag.
// New values are staged in a pending register and only reach the display
// register at a frame wrap, so a frame never mixes old and new digits.
// Leading-zero blanking and whole-display blinking are supported.
// All outputs decode from registered state; blank_lz and blink_en are
// sampled into flops first, so they take effect one cycle after they change.

module seg7_scan_ctrl #(
   parameter int DIGITS       = 4,
   parameter int SCAN_DIV     = 50000,
   parameter int BLINK_FRAMES = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   value,
   input  logic                  blank_lz,
   input  logic                  blink_en,
   output logic [3:0]            nibble,
   output logic [DIGITS-1:0]     digit_en,
   output logic                  blank,
   output logic                  frame_done
);

   // Counter widths are kept at least one bit wide so degenerate
   // parameter values (1) still give legal vectors.
   localparam int PW = (SCAN_DIV     > 1) ? $clog2(SCAN_DIV)     : 1;
   localparam int IW = (DIGITS       > 1) ? $clog2(DIGITS)       : 1;
   localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [PW-1:0] PS_LAST  = PW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
   localparam logic [FW-1:0] FR_LAST  = FW'(BLINK_FRAMES - 1);

   logic [PW-1:0]         prescaler;
   logic [IW-1:0]         index;
   logic [4*DIGITS-1:0]   display;
   logic [4*DIGITS-1:0]   pending;
   logic                  pending_valid;
   logic [FW-1:0]         frame_cnt;
   logic                  phase;
   logic                  frame_done_q;
   logic                  blank_lz_q;
   logic                  blink_en_q;

   logic                  tick;
   logic                  wrap;
   logic [DIGITS-1:0]     zero_from;
   logic                  lz_cur;

   assign tick = (prescaler == PS_LAST);
   assign wrap = tick && (index == IDX_LAST);

   // Slot prescaler: one tick every SCAN_DIV cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prescaler <= '0;
      end else if (tick) begin
         prescaler <= '0;
      end else begin
         prescaler <= prescaler + PW'(1);
      end
   end

   // Digit index advances on each tick and wraps at the last digit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         index <= '0;
      end else if (tick) begin
         if (index == IDX_LAST) begin
            index <= '0;
         end else begin
            index <= index + IW'(1);
         end
      end
   end

   // Value staging: loads park in pending and are promoted only at a wrap.
   // A load arriving on the wrap cycle itself is the newest value, so it
   // goes straight to the display and supersedes anything pending.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         display       <= '0;
         pending       <= '0;
         pending_valid <= 1'b0;
      end else if (wrap) begin
         if (load) begin
            display <= value;
         end else if (pending_valid) begin
            display <= pending;
         end
         pending_valid <= 1'b0;
      end else if (load) begin
         pending       <= value;
         pending_valid <= 1'b1;
      end
   end

   // Blink timebase: counts frames and flips phase every BLINK_FRAMES,
   // free-running so enabling blink does not restart the pattern.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt <= '0;
         phase     <= 1'b0;
      end else if (wrap) begin
         if (frame_cnt == FR_LAST) begin
            frame_cnt <= '0;
            phase     <= ~phase;
         end else begin
            frame_cnt <= frame_cnt + FW'(1);
         end
      end
   end

   // Frame pulse and registered copies of the level controls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_done_q <= 1'b0;
         blank_lz_q   <= 1'b0;
         blink_en_q   <= 1'b0;
      end else begin
         frame_done_q <= wrap;
         blank_lz_q   <= blank_lz;
         blink_en_q   <= blink_en;
      end
   end

   // zero_from[i] is set when every digit from the top down to i is zero.
   always_comb begin
      logic acc;
      acc       = 1'b1;
      zero_from = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         acc          = acc && (display[4*i +: 4] == 4'h0);
         zero_from[i] = acc;
      end
   end

   // Digit mux, one-hot enable and leading-zero lookup for the active slot.
   // Digit 0 is excluded from leading-zero blanking so zero shows as "0".
   always_comb begin
      nibble   = 4'h0;
      digit_en = '0;
      lz_cur   = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (index == IW'(i)) begin
            nibble      = display[4*i +: 4];
            digit_en[i] = 1'b1;
            lz_cur      = (i != 0) && zero_from[i];
         end
      end
   end

   assign blank      = (blink_en_q && phase) || (blank_lz_q && lz_cur);
   assign frame_done = frame_done_q;

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
Time-multiplexed digit sequencer that sits directly upstream of the 7-segment decoder. It holds a multi-digit hex value and presents one 4-bit nibble per scan slot to the decoder, with a one-hot digit enable and a blank flag. It provides tear-free frame-synchronous value updates, leading-zero blanking and whole-display blinking. The comparator display path uses it to drive HEX0..HEX3 through a single decoder instance.

Parameters:
DIGITS, 4, number of hex digits scanned (>=1)
SCAN_DIV, 50000, clk cycles per digit slot (>=1)
BLINK_FRAMES, 64, full scan frames per blink half-period (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
load  in  1  single-cycle strobe: capture value
value  in  4*DIGITS  hex value; digit i = value[4i+3:4i], digit 0 is least significant
blank_lz  in  1  level: enable leading-zero blanking
blink_en  in  1  level: enable display blinking
nibble  out  4  current digit's value, to decoder bnum
digit_en  out  DIGITS  one-hot select of the current digit
blank  out  1  1 = current digit must be dark (decoder output overridden to all-off)
frame_done  out  1  one-cycle pulse on frame wrap

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst_n. All state resets asynchronously.
- Reset values: prescaler 0, digit index 0, display reg 0, pending reg 0, pending_valid 0, frame counter 0, blink phase 0. Outputs: nibble=0, digit_en=one-hot bit 0, blank=0, frame_done=0.
- Prescaler counts 0..SCAN_DIV-1. tick = (prescaler==SCAN_DIV-1), then the prescaler wraps to 0. With SCAN_DIV=1, tick is asserted every cycle.
- On tick, the digit index advances and wraps DIGITS-1 -> 0. wrap = tick && index==DIGITS-1.
- frame_done is registered: high for exactly the cycle after a wrap.
- Load handling:
  - load and not wrap: pending <= value, pending_valid <= 1. A later load before the wrap overwrites pending.
  - wrap and load in the same cycle: display <= value (the load wins over pending), pending_valid <= 0.
  - wrap without load: if pending_valid then display <= pending and pending_valid <= 0; otherwise display holds.
  - The display reg never changes except at a wrap, so no frame shows mixed old and new digits.
- Blink:
  - Frame counter counts wraps 0..BLINK_FRAMES-1. On the wrap where it is at BLINK_FRAMES-1, it returns to 0 and blink phase toggles.
  - The counter and phase run regardless of blink_en.
- Outputs are decoded from registered state only; there is no combinational path from inputs.
  - nibble = display digit[index]; digit_en = one-hot(index).
  - blank = (blink_en && phase) || lz_blank(index).
  - lz_blank(i) = blank_lz && i!=0 && every display digit from DIGITS-1 down to i is 0. Digit 0 is never LZ-blanked.
- nibble carries the real digit value even when blank=1.
- Reset mid-frame returns to digit 0, display 0, and discards any pending load.

Test Plan:
- Reset, then release with DIGITS=4, SCAN_DIV=4. Required: digit_en cycles 0001->0010->0100->1000->0001, each held 4 clocks. frame_done pulses once per 16 clocks. nibble=0, blank=0.
- load with value=16'h1A3F mid-frame (index 1). Required: nibble stays 0 until the wrap. The next frame shows F,3,A,1 on digits 0..3.
- Two loads in one frame, 16'h1111 then 16'h2222. Required: the next frame shows only 2s. A load coincident with the wrap tick of 16'h3333 appears in that very next frame (0->3 at index 0).
- blank_lz=1, display 16'h0070. Required: digits 3 and 2 blank=1, digit 1 nibble 7 blank=0, digit 0 nibble 0 blank=0. For display 16'h0000, only digit 0 is unblanked.
- BLINK_FRAMES=2, blink_en=1. Required: blank=1 on all digits for frames 2-3, 6-7, and so on, and 0 for frames 0-1, 4-5. Dropping blink_en during a dark frame clears blank on the next cycle.
- Assert rst_n=0 mid-frame with pending_valid=1. Required: outputs return to reset values asynchronously. After release, the display shows 0 and the old pending value never appears.
